// File: rtl/muldiv_sched_if.sv
// Operand/command and HI/LO result bundle between the E stage and the mul/div unit.
interface muldiv_sched_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        d_use_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_o;

  modport master (
    output start, op, a, b, cancel, d_use_md,
    input  hi, lo, busy, stall_o
  );

  modport slave (
    input  start, op, a, b, cancel, d_use_md,
    output hi, lo, busy, stall_o
  );
endinterface

// File: rtl/muldiv_sched.sv
// Fixed-latency mul/div sequencer owning HI/LO; busy for MULT_CYC/DIV_CYC cycles,
// results land on the completion edge, stall_o holds D while HI/LO is occupied.
module muldiv_sched #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  muldiv_sched_if.slave  md
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  op_q,    op_d;
  logic [31:0] a_q,     a_d;
  logic [31:0] b_q,     b_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;

  // One shared datapath: op_q[0] clear selects the signed variants.
  logic        sgn;
  logic [63:0] ext_a, ext_b, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, div_b, uq, ur, quo, rem;

  assign sgn   = ~op_q[0];
  assign ext_a = {{32{sgn & a_q[31]}}, a_q};
  assign ext_b = {{32{sgn & b_q[31]}}, b_q};
  assign prod  = ext_a * ext_b;

  // Magnitude divide avoids the signed-overflow corner of 0x80000000 / -1.
  assign neg_a = sgn & a_q[31];
  assign neg_b = sgn & b_q[31];
  assign mag_a = neg_a ? (~a_q + 32'd1) : a_q;
  assign mag_b = neg_b ? (~b_q + 32'd1) : b_q;
  assign div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign uq    = mag_a / div_b;
  assign ur    = mag_a % div_b;
  assign quo   = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
  assign rem   = neg_a ? (~ur + 32'd1) : ur;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (md.start && !md.cancel) begin
          if (!md.op[2]) begin
            op_d    = md.op[1:0];
            a_d     = md.a;
            b_d     = md.b;
            count_d = md.op[1] ? 4'(DIV_CYC) : 4'(MULT_CYC);
            state_d = RUN;
          end else if (md.op == 3'd4) begin
            hi_d = md.a;
          end else if (md.op == 3'd5) begin
            lo_d = md.a;
          end
        end
      end
      RUN: begin
        if (md.cancel) begin
          state_d = IDLE;
          count_d = 4'd0;
        end else if (count_q == 4'd1) begin
          state_d = IDLE;
          count_d = 4'd0;
          if (!op_q[1]) begin
            {hi_d, lo_d} = prod;
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.hi      = hi_q;
  assign md.lo      = lo_q;
  assign md.busy    = (state_q == RUN);
  assign md.stall_o = md.d_use_md & ((state_q == RUN) | (md.start & (md.op <= 3'd3)));

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: hand-computed HI/LO results, busy length, stall and abort cases.
module tb_muldiv_sched;
  logic clk;
  logic reset_n;
  int   errs;
  int   n_chk;
  int   nb;

  muldiv_sched_if md ();

  muldiv_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Count busy cycles until idle, bounded so a stuck unit cannot hang the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (md.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md.start = 1'b1;
    md.op    = op;
    md.a     = a;
    md.b     = b;
    tick();
    md.start = 1'b0;
    md.op    = 3'd7;
  endtask

  initial begin
    errs = 0;
    n_chk = 0;
    reset_n     = 1'b0;
    md.start    = 1'b0;
    md.op       = 3'd7;
    md.a        = 32'd0;
    md.b        = 32'd0;
    md.cancel   = 1'b0;
    md.d_use_md = 1'b0;
    #13;
    check("rst_hi", md.hi, 32'd0);
    check("rst_lo", md.lo, 32'd0);
    check("rst_busy", {31'd0, md.busy}, 32'd0);
    reset_n = 1'b1;
    tick();

    // MULT -2 * 3 with a dependent instruction sitting in D.
    md.d_use_md = 1'b1;
    md.start = 1'b1; md.op = 3'd0; md.a = 32'hFFFFFFFE; md.b = 32'd3;
    #1;
    check("mult_stall_start", {31'd0, md.stall_o}, 32'd1);
    check("mult_busy_start", {31'd0, md.busy}, 32'd0);
    @(posedge clk); #2;
    md.start = 1'b0; md.op = 3'd7;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("mult_busy_c%0d", i), {31'd0, md.busy}, 32'd1);
      check($sformatf("mult_stall_c%0d", i), {31'd0, md.stall_o}, 32'd1);
      tick();
    end
    check("mult_busy_end", {31'd0, md.busy}, 32'd0);
    check("mult_stall_end", {31'd0, md.stall_o}, 32'd0);
    check("mult_hi", md.hi, 32'hFFFFFFFF);
    check("mult_lo", md.lo, 32'hFFFFFFFA);
    md.d_use_md = 1'b0;

    // MULTU with a stray start in busy cycle 3.
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    tick(); tick();
    md.start = 1'b1; md.op = 3'd0; md.a = 32'd5; md.b = 32'd5;
    tick();
    md.start = 1'b0; md.op = 3'd7;
    tick(); tick();
    check("multu_busy_end", {31'd0, md.busy}, 32'd0);
    check("multu_hi", md.hi, 32'h00000001);
    check("multu_lo", md.lo, 32'hFFFFFFFE);
    tick();
    check("multu_no_rerun", {31'd0, md.busy}, 32'd0);

    // DIV -7 / 2, DIVU same operands, overflow corner.
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(nb);
    check("div_cycles", nb, 32'd10);
    check("div_lo", md.lo, 32'hFFFFFFFD);
    check("div_hi", md.hi, 32'hFFFFFFFF);
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(nb);
    check("divu_cycles", nb, 32'd10);
    check("divu_lo", md.lo, 32'h7FFFFFFC);
    check("divu_hi", md.hi, 32'h00000001);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(nb);
    check("divovf_lo", md.lo, 32'h80000000);
    check("divovf_hi", md.hi, 32'h00000000);

    // MTHI/MTLO back to back, then divide by zero.
    md.start = 1'b1; md.op = 3'd4; md.a = 32'h1234;
    tick();
    check("mthi_busy", {31'd0, md.busy}, 32'd0);
    md.op = 3'd5; md.a = 32'h5678;
    tick();
    md.start = 1'b0; md.op = 3'd7;
    check("mtlo_busy", {31'd0, md.busy}, 32'd0);
    check("mt_hi", md.hi, 32'h1234);
    check("mt_lo", md.lo, 32'h5678);
    issue(3'd2, 32'd99, 32'd0);
    wait_idle(nb);
    check("div0_cycles", nb, 32'd10);
    check("div0_hi", md.hi, 32'h1234);
    check("div0_lo", md.lo, 32'h5678);

    // Cancel in busy cycle 4, then cancel on the completion edge.
    issue(3'd2, 32'd100, 32'd7);
    tick(); tick(); tick();
    md.cancel = 1'b1;
    tick();
    md.cancel = 1'b0;
    check("cancel4_busy", {31'd0, md.busy}, 32'd0);
    check("cancel4_hi", md.hi, 32'h1234);
    check("cancel4_lo", md.lo, 32'h5678);
    issue(3'd2, 32'd100, 32'd7);
    for (int i = 1; i < 10; i++) tick();
    check("cancel10_busy_pre", {31'd0, md.busy}, 32'd1);
    md.cancel = 1'b1;
    tick();
    md.cancel = 1'b0;
    check("cancel10_busy", {31'd0, md.busy}, 32'd0);
    check("cancel10_hi", md.hi, 32'h1234);
    check("cancel10_lo", md.lo, 32'h5678);

    // Cancel in IDLE suppresses a same-cycle start.
    md.cancel = 1'b1;
    issue(3'd0, 32'd3, 32'd3);
    md.cancel = 1'b0;
    check("cancel_idle_busy", {31'd0, md.busy}, 32'd0);
    tick(); tick(); tick(); tick(); tick();
    check("cancel_idle_lo", md.lo, 32'h5678);

    // Asynchronous reset mid-MULT.
    issue(3'd0, 32'd6, 32'd7);
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_hi", md.hi, 32'd0);
    check("arst_lo", md.lo, 32'd0);
    check("arst_busy", {31'd0, md.busy}, 32'd0);
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("arst_post_busy", {31'd0, md.busy}, 32'd0);
    check("arst_post_hi", md.hi, 32'd0);
    check("arst_post_lo", md.lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end
endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Multi-cycle multiply/divide sequencer and HI/LO register owner for the 5-stage MIPS pipeline.
- Accepts an operation from the E stage and runs a fixed-latency busy countdown.
- Commits results to HI/LO on completion.
- Raises a stall request toward the F/D pipeline register whenever the D-stage instruction needs HI/LO while the unit is occupied.

Parameters:
- MULT_CYC, 5, busy cycles for MULT/MULTU (range 1..15)
- DIV_CYC, 10, busy cycles for DIV/DIVU (range 1..15)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  E-stage instruction is a valid mul/div/mt op this cycle
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op
- a  input  32  rs operand (forwarded)
- b  input  32  rt operand (forwarded)
- cancel  input  1  abort in-flight op (pipeline flush)
- d_use_md  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  operation in flight
- stall_o  output  1  stall request to F/D

Behaviour:
- Reset: asynchronous on reset_n low. hi=0, lo=0, busy=0, count=0, state=IDLE. Reset mid-operation discards the op; no HI/LO write occurs.
- States: IDLE, RUN.
- IDLE, start=1, op in 0..3:
  - Latch op, a and b.
  - count = MULT_CYC (op 0,1) or DIV_CYC (op 2,3); go to RUN.
  - busy goes high from the next cycle.
- IDLE, start=1, op=4/5: hi (resp. lo) = a at that edge. Stays IDLE; busy stays 0.
- IDLE, op 6/7: ignored.
- RUN: count decrements every edge. On the edge where count==1:
  - Write hi/lo from the latched operands.
  - Go to IDLE, busy=0.
  - busy is therefore high for exactly N cycles, and the result is visible in the cycle busy drops.
- start while in RUN: ignored (the hazard logic prevents it; hi/lo are not corrupted).
- cancel=1 in RUN: go to IDLE next edge, count=0, hi/lo unchanged. cancel outranks completion on the same edge.
- cancel=1 in IDLE: start on the same cycle is suppressed.
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = quotient truncated toward zero, hi = remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (b==0): hi/lo unchanged; busy timing identical.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- stall_o = d_use_md & (busy | (start & op<=3)). Combinational from inputs and state, so mfhi/mflo in D waits through the start cycle as well.
- Outputs hi/lo are registers, with no combinational bypass of results.

Test Plan:
- Reset then MULT a=0xFFFFFFFE (-2), b=3 → busy high 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA. With d_use_md=1: stall_o high on the start cycle plus the 5 busy cycles, then low.
- MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles. A second start issued in cycle 3 is ignored; result unchanged.
- DIV a=0xFFFFFFF9 (-7), b=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands → lo=0x7FFFFFFC, hi=0x1.
- Preload MTHI a=0x1234, then MTLO a=0x5678 in consecutive cycles → hi=0x1234, lo=0x5678, busy never asserted. Then DIV b=0 → after 10 cycles hi/lo still 0x1234/0x5678.
- DIV started, cancel pulsed in busy cycle 4 → busy low next cycle, hi/lo unchanged. Repeat with cancel on the completion edge → no write.
- MULT in flight, reset_n pulsed low mid-cycle (asynchronous, not clock-aligned) → hi=lo=0 and busy=0 immediately; no write after release.
